// File: rtl/capping_station_ctrl.sv
// Capping-station sequencer. Runs the conveyor, stops each bottle under the
// capper, pulses the cap command toward the cork counter, and raises the
// alarm lamp when the dispenser is empty or a bottle fails to clear.
//
//   state    | code | meaning
//   IDLE     | 0    | conveyor stopped, waiting for run enable
//   ADVANCE  | 1    | conveyor running, waiting for a bottle edge
//   CHECK    | 2    | bottle in position, one-cycle cork availability test
//   CAP      | 3    | cap command held for CAP_CYCLES cycles
//   RELEASE  | 4    | conveyor running, waiting for the capped bottle to leave
//   NO_CORK  | 5    | bottle waiting for corks, alarm on
//   JAM      | 6    | bottle failed to leave, alarm on, reset required
module capping_station_ctrl #(
  parameter int CAP_CYCLES  = 8,
  parameter int POS_TIMEOUT = 32,
  parameter int CNT_W       = 8
) (
  input  logic             CLKplaca,
  input  logic             reset,
  input  logic             habilita,
  input  logic             sensor_garrafa,
  input  logic             tem_rolha,
  output logic             motor,
  output logic             tampar,
  output logic             alarme,
  output logic [CNT_W-1:0] garrafas_tampadas,
  output logic [2:0]       estado
);

  localparam int CAP_W = $clog2(CAP_CYCLES + 1);
  localparam int TMO_W = $clog2(POS_TIMEOUT + 1);

  localparam logic [CAP_W-1:0] CAP_LAST  = CAP_W'(CAP_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(POS_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ADVANCE = 3'd1;
  localparam logic [2:0] S_CHECK   = 3'd2;
  localparam logic [2:0] S_CAP     = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;
  localparam logic [2:0] S_NO_CORK = 3'd5;
  localparam logic [2:0] S_JAM     = 3'd6;

  logic             s1_q, s2_q;
  logic             sens_rise, sens_high;
  logic [2:0]       state_q, state_d;
  logic [CAP_W-1:0] cap_q, cap_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [TMO_W-1:0] tmo_inc;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Two-flop synchroniser for the asynchronous bottle sensor.
  always_ff @(posedge CLKplaca) begin
    if (!reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= sensor_garrafa;
      s2_q <= s1_q;
    end
  end

  assign sens_rise = s1_q & ~s2_q;
  assign sens_high = s1_q;
  assign tmo_inc   = tmo_q + TMO_W'(1);

  // Next-state, pulse timer, position timeout and capped-bottle count.
  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    tmo_d   = tmo_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (habilita) state_d = S_ADVANCE;
      end
      S_ADVANCE: begin
        // A bottle edge wins over a run-enable drop so an arriving bottle is never skipped.
        if (sens_rise)      state_d = S_CHECK;
        else if (!habilita) state_d = S_IDLE;
      end
      S_CHECK: begin
        if (tem_rolha) begin
          state_d = S_CAP;
          cap_d   = '0;
        end else begin
          state_d = S_NO_CORK;
        end
      end
      S_CAP: begin
        // Capping is atomic: enable and cork level are not looked at here.
        if (cap_q == CAP_LAST) begin
          state_d = S_RELEASE;
          tmo_d   = '0;
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cap_d = cap_q + CAP_W'(1);
        end
      end
      S_RELEASE: begin
        if (!sens_high) begin
          state_d = habilita ? S_ADVANCE : S_IDLE;
          tmo_d   = '0;
        end else if (tmo_inc == TMO_LIMIT) begin
          state_d = S_JAM;
          tmo_d   = tmo_inc;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      S_NO_CORK: begin
        // Bottle is still under the capper, so enable is ignored until corks return.
        if (tem_rolha) begin
          state_d = S_CAP;
          cap_d   = '0;
        end
      end
      S_JAM: begin
        state_d = S_JAM;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge CLKplaca) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cap_q   <= '0;
      tmo_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
    end
  end

  // Moore outputs decoded from the state register only.
  always_comb begin
    motor  = 1'b0;
    tampar = 1'b0;
    alarme = 1'b0;
    case (state_q)
      S_ADVANCE: motor  = 1'b1;
      S_RELEASE: motor  = 1'b1;
      S_CAP:     tampar = 1'b1;
      S_NO_CORK: alarme = 1'b1;
      S_JAM:     alarme = 1'b1;
      default: begin
        motor  = 1'b0;
        tampar = 1'b0;
        alarme = 1'b0;
      end
    endcase
  end

  assign garrafas_tampadas = cnt_q;
  assign estado            = state_q;

endmodule

// File: tb/tb_capping_station_ctrl.sv
// Self-checking bench for capping_station_ctrl: directed scenarios plus
// randomized bottle episodes judged against a bottle-level outcome model.
module tb_capping_station_ctrl;

  logic       CLKplaca;
  logic       reset;
  logic       habilita;
  logic       sensor_garrafa;
  logic       tem_rolha;
  logic       motor;
  logic       tampar;
  logic       alarme;
  logic [7:0] garrafas_tampadas;
  logic [2:0] estado;

  int errors = 0;
  int checks = 0;
  int model_cnt = 0;

  capping_station_ctrl #(.CAP_CYCLES(8), .POS_TIMEOUT(32), .CNT_W(8)) dut (
    .CLKplaca          (CLKplaca),
    .reset             (reset),
    .habilita          (habilita),
    .sensor_garrafa    (sensor_garrafa),
    .tem_rolha         (tem_rolha),
    .motor             (motor),
    .tampar            (tampar),
    .alarme            (alarme),
    .garrafas_tampadas (garrafas_tampadas),
    .estado            (estado)
  );

  initial CLKplaca = 1'b0;
  always #5 CLKplaca = ~CLKplaca;

  task automatic tick();
    @(posedge CLKplaca);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Bounded wait for a state code; an expired bound shows up as a failed check.
  task automatic wait_for(input logic [2:0] s, input int max, input string tag);
    int k;
    k = 0;
    while (estado !== s && k < max) begin
      tick();
      k++;
    end
    check(tag, {29'd0, estado}, {29'd0, s});
  endtask

  // One bottle from arrival to departure; the model only knows bottle-level rules:
  // a cap pulse is 8 cycles, the count saturates at 255, an empty dispenser parks
  // the bottle with the alarm on, and leaving goes to run or stop per the enable.
  task automatic do_bottle(input bit cork, input int cork_delay, input int hold,
                           input bit hab_after, input bit drop_hab_mid_cap);
    int n;
    int exp_cnt;
    exp_cnt = (model_cnt == 255) ? 255 : model_cnt + 1;
    habilita       = 1'b1;
    tem_rolha      = cork;
    sensor_garrafa = 1'b0;
    wait_for(3'd1, 20, "advance");
    tick();
    tick();
    sensor_garrafa = 1'b1;
    if (cork) begin
      wait_for(3'd2, 10, "check_state");
      tick();
      check("cap_entry", {29'd0, estado}, 32'd3);
    end else begin
      wait_for(3'd5, 10, "no_cork_state");
      check("no_cork_alarm", {31'd0, alarme}, 32'd1);
      check("no_cork_motor", {31'd0, motor}, 32'd0);
      habilita = 1'b0;
      repeat (cork_delay) tick();
      check("no_cork_hold", {29'd0, estado}, 32'd5);
      tem_rolha = 1'b1;
      tick();
      check("no_cork_to_cap", {29'd0, estado}, 32'd3);
      check("cap_alarm_off", {31'd0, alarme}, 32'd0);
    end
    n = 0;
    while (estado === 3'd3 && n < 20) begin
      if (tampar === 1'b1) n++;
      if (n == 2) tem_rolha = 1'($urandom_range(0, 1));
      if (n == 3 && drop_hab_mid_cap) habilita = 1'b0;
      tick();
    end
    check("tampar_len", n, 32'd8);
    check("release_state", {29'd0, estado}, 32'd4);
    check("release_motor", {31'd0, motor}, 32'd1);
    check("count", {24'd0, garrafas_tampadas}, exp_cnt);
    model_cnt = exp_cnt;
    if (!drop_hab_mid_cap) habilita = hab_after;
    else habilita = 1'b0;
    repeat (hold) tick();
    sensor_garrafa = 1'b0;
    wait_for((hab_after && !drop_hab_mid_cap) ? 3'd1 : 3'd0, 6, "release_exit");
  endtask

  initial begin
    int n;
    reset          = 1'b0;
    habilita       = 1'b0;
    sensor_garrafa = 1'b0;
    tem_rolha      = 1'b0;

    // Reset state
    tick();
    check("rst_estado", {29'd0, estado}, 32'd0);
    check("rst_motor", {31'd0, motor}, 32'd0);
    check("rst_tampar", {31'd0, tampar}, 32'd0);
    check("rst_alarme", {31'd0, alarme}, 32'd0);
    check("rst_count", {24'd0, garrafas_tampadas}, 32'd0);

    // Enable after reset: running on the second edge
    reset    = 1'b1;
    habilita = 1'b1;
    tick();
    check("run_estado", {29'd0, estado}, 32'd1);
    check("run_motor", {31'd0, motor}, 32'd1);

    // Normal bottle, then bottle with empty dispenser refilled after 20 cycles
    do_bottle(1'b1, 0, 3, 1'b1, 1'b0);
    do_bottle(1'b0, 20, 3, 1'b1, 1'b0);

    // Sensor already high when leaving IDLE: no capping without a fresh edge
    habilita = 1'b0;
    wait_for(3'd0, 5, "stop_idle");
    sensor_garrafa = 1'b1;
    repeat (4) tick();
    habilita = 1'b1;
    repeat (8) tick();
    check("no_rise_stays_adv", {29'd0, estado}, 32'd1);
    sensor_garrafa = 1'b0;
    repeat (3) tick();
    do_bottle(1'b1, 0, 1, 1'b1, 1'b0);

    // Bottle never leaves: JAM after 32 RELEASE cycles
    tem_rolha = 1'b1;
    tick();
    tick();
    sensor_garrafa = 1'b1;
    wait_for(3'd3, 10, "jam_cap");
    wait_for(3'd4, 12, "jam_release");
    n = 0;
    while (estado === 3'd4 && n < 60) begin
      n++;
      tick();
    end
    check("release_cycles", n, 32'd32);
    check("jam_state", {29'd0, estado}, 32'd6);
    check("jam_alarm", {31'd0, alarme}, 32'd1);
    check("jam_motor", {31'd0, motor}, 32'd0);
    check("jam_count", {24'd0, garrafas_tampadas}, model_cnt + 1);
    sensor_garrafa = 1'b0;
    repeat (5) tick();
    check("jam_sticky", {29'd0, estado}, 32'd6);
    reset = 1'b0;
    tick();
    check("jam_reset_estado", {29'd0, estado}, 32'd0);
    check("jam_reset_count", {24'd0, garrafas_tampadas}, 32'd0);
    check("jam_reset_alarm", {31'd0, alarme}, 32'd0);
    model_cnt = 0;
    reset = 1'b1;

    // Reset on the third CAP cycle
    habilita = 1'b1;
    wait_for(3'd1, 5, "mid_adv");
    tick();
    tick();
    sensor_garrafa = 1'b1;
    wait_for(3'd3, 10, "mid_cap");
    tick();
    tick();
    check("mid_tampar_on", {31'd0, tampar}, 32'd1);
    reset = 1'b0;
    tick();
    check("mid_rst_tampar", {31'd0, tampar}, 32'd0);
    check("mid_rst_estado", {29'd0, estado}, 32'd0);
    check("mid_rst_count", {24'd0, garrafas_tampadas}, 32'd0);
    sensor_garrafa = 1'b0;
    reset = 1'b1;
    repeat (3) tick();

    // Randomized bottle episodes
    for (int i = 0; i < 12; i++) begin
      do_bottle(1'($urandom_range(0, 1)), $urandom_range(1, 25), $urandom_range(0, 20),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Fill to saturation, then one more with enable dropped mid-CAP
    while (model_cnt < 255) do_bottle(1'b1, 0, 0, 1'b1, 1'b0);
    check("sat_fill", {24'd0, garrafas_tampadas}, 32'd255);
    do_bottle(1'b1, 0, 2, 1'b0, 1'b1);
    check("sat_hold", {24'd0, garrafas_tampadas}, 32'd255);
    check("sat_idle", {29'd0, estado}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
